// File: rtl/sync_level_debounce.sv
// Glitch filter for a synchronized clkB-domain level: clean level, rise/fall strobes, saturating rise counter.
// Optional rejected-glitch counter enabled by defining SYNC_DEBOUNCE_GLITCH_CNT_EN.
module sync_level_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned QCNT_W          = 16,
  parameter int unsigned CNT_W           = 16,
  parameter bit          INIT_LEVEL      = 1'b0
) (
  input  logic             clkB,
  input  logic             rstB,
  input  logic             sig_in,
  input  logic             cnt_clr,
  output logic             level_out,
  output logic             rise_pls,
  output logic             fall_pls,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             busy
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [CNT_W-1:0] glitch_cnt
`endif
);

  localparam int unsigned      QW1      = QCNT_W + 1;
  localparam logic [QCNT_W:0]  N_Q      = QW1'(DEBOUNCE_CYCLES);
  localparam bit               ONE_SHOT = (DEBOUNCE_CYCLES == 1);

  typedef enum logic [1:0] {
    ST_LO   = 2'd0,
    QUAL_HI = 2'd1,
    ST_HI   = 2'd2,
    QUAL_LO = 2'd3
  } state_e;

  localparam state_e RST_STATE = INIT_LEVEL ? ST_HI : ST_LO;

  state_e              state_q;
  logic [QCNT_W-1:0]   qcnt_q;
  logic                level_q;
  logic                rise_q;
  logic                fall_q;
  logic                busy_q;
  logic [CNT_W-1:0]    edge_cnt_q;

  logic [QCNT_W:0]     qcnt_inc;
  logic                qual_done;
  logic                rise_evt;
  logic                abort_evt;

  // Extra top bit keeps the qualification compare exact even when qcnt is near full scale.
  assign qcnt_inc  = QW1'(qcnt_q) + QW1'(1);
  assign qual_done = (qcnt_inc == N_Q);

  assign rise_evt  = ((state_q == ST_LO) && sig_in && ONE_SHOT) ||
                     ((state_q == QUAL_HI) && sig_in && qual_done);
  assign abort_evt = ((state_q == QUAL_HI) && !sig_in) ||
                     ((state_q == QUAL_LO) && sig_in);

  // Qualification FSM; level, strobes and busy are registered alongside the state.
  always_ff @(posedge clkB or posedge rstB) begin
    if (rstB) begin
      state_q <= RST_STATE;
      qcnt_q  <= '0;
      level_q <= INIT_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        ST_LO: begin
          if (sig_in) begin
            if (ONE_SHOT) begin
              state_q <= ST_HI;
              level_q <= 1'b1;
              rise_q  <= 1'b1;
            end else begin
              state_q <= QUAL_HI;
              qcnt_q  <= QCNT_W'(1);
              busy_q  <= 1'b1;
            end
          end
        end
        QUAL_HI: begin
          if (!sig_in) begin
            state_q <= ST_LO;
            qcnt_q  <= '0;
            busy_q  <= 1'b0;
          end else if (qual_done) begin
            state_q <= ST_HI;
            qcnt_q  <= '0;
            level_q <= 1'b1;
            rise_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            qcnt_q  <= qcnt_inc[QCNT_W-1:0];
          end
        end
        ST_HI: begin
          if (!sig_in) begin
            if (ONE_SHOT) begin
              state_q <= ST_LO;
              level_q <= 1'b0;
              fall_q  <= 1'b1;
            end else begin
              state_q <= QUAL_LO;
              qcnt_q  <= QCNT_W'(1);
              busy_q  <= 1'b1;
            end
          end
        end
        QUAL_LO: begin
          if (sig_in) begin
            state_q <= ST_HI;
            qcnt_q  <= '0;
            busy_q  <= 1'b0;
          end else if (qual_done) begin
            state_q <= ST_LO;
            qcnt_q  <= '0;
            level_q <= 1'b0;
            fall_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            qcnt_q  <= qcnt_inc[QCNT_W-1:0];
          end
        end
        default: begin
          state_q <= RST_STATE;
          qcnt_q  <= '0;
          level_q <= INIT_LEVEL;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of accepted rises; clear has priority over a same-edge increment.
  always_ff @(posedge clkB or posedge rstB) begin
    if (rstB) begin
      edge_cnt_q <= '0;
    end else if (cnt_clr) begin
      edge_cnt_q <= '0;
    end else if (rise_evt && (edge_cnt_q != '1)) begin
      edge_cnt_q <= edge_cnt_q + CNT_W'(1);
    end
  end

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  logic [CNT_W-1:0] glitch_cnt_q;

  // Saturating count of candidate changes abandoned before qualification completed.
  always_ff @(posedge clkB or posedge rstB) begin
    if (rstB) begin
      glitch_cnt_q <= '0;
    end else if (cnt_clr) begin
      glitch_cnt_q <= '0;
    end else if (abort_evt && (glitch_cnt_q != '1)) begin
      glitch_cnt_q <= glitch_cnt_q + CNT_W'(1);
    end
  end

  assign glitch_cnt = glitch_cnt_q;
`else
  logic unused_abort;
  assign unused_abort = abort_evt;
`endif

  assign level_out = level_q;
  assign rise_pls  = rise_q;
  assign fall_pls  = fall_q;
  assign edge_cnt  = edge_cnt_q;
  assign busy      = busy_q;

  a_strobe_excl: assert property (@(posedge clkB) disable iff (rstB) !(rise_q && fall_q));
  a_busy_state:  assert property (@(posedge clkB) disable iff (rstB)
                   busy_q == ((state_q == QUAL_HI) || (state_q == QUAL_LO)));

endmodule

// File: tb/tb_sync_level_debounce.sv
// Directed bench for sync_level_debounce: main instance (N=4, CNT_W=16) plus a CNT_W=4 instance for saturation.
module tb_sync_level_debounce;

  logic clk = 1'b0;
  logic rst;
  logic sig;
  logic clr;
  logic sig2;
  logic clr2;

  logic        level, rise, fall, busy;
  logic [15:0] ecnt;
  logic        level2, rise2, fall2, busy2;
  logic [3:0]  ecnt2;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  logic [15:0] gcnt;
  logic [3:0]  gcnt2;
`endif

  int checks   = 0;
  int failures = 0;
  logic seen;

  always #5 clk = ~clk;

  sync_level_debounce #(.DEBOUNCE_CYCLES(4), .QCNT_W(16), .CNT_W(16), .INIT_LEVEL(1'b0)) u_dut (
    .clkB      (clk),
    .rstB      (rst),
    .sig_in    (sig),
    .cnt_clr   (clr),
    .level_out (level),
    .rise_pls  (rise),
    .fall_pls  (fall),
    .edge_cnt  (ecnt),
    .busy      (busy)
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt(gcnt)
`endif
  );

  sync_level_debounce #(.DEBOUNCE_CYCLES(4), .QCNT_W(8), .CNT_W(4), .INIT_LEVEL(1'b0)) u_sat (
    .clkB      (clk),
    .rstB      (rst),
    .sig_in    (sig2),
    .cnt_clr   (clr2),
    .level_out (level2),
    .rise_pls  (rise2),
    .fall_pls  (fall2),
    .edge_cnt  (ecnt2),
    .busy      (busy2)
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt(gcnt2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clkB edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_watch(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      seen = seen | rise | fall;
    end
  endtask

  initial begin
    rst = 1'b1; sig = 1'b0; clr = 1'b0; sig2 = 1'b0; clr2 = 1'b0;
    tick(); tick();
    check("rst_level", 32'(level), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_ecnt",  32'(ecnt),  32'd0);
    check("rst_strb",  32'({rise, fall}), 32'd0);
    rst = 1'b0;

    // Idle low for 20 cycles
    seen = 1'b0;
    tick_watch(20);
    check("idle_strb",  32'(seen),  32'd0);
    check("idle_level", 32'(level), 32'd0);
    check("idle_busy",  32'(busy),  32'd0);
    check("idle_ecnt",  32'(ecnt),  32'd0);

    // Three-cycle glitch is rejected
    sig = 1'b1;
    tick(); check("gl_busy1", 32'(busy), 32'd1);
    tick(); check("gl_busy2", 32'(busy), 32'd1);
    tick(); check("gl_busy3", 32'(busy), 32'd1);
    check("gl_level3", 32'(level), 32'd0);
    sig = 1'b0;
    tick();
    check("gl_busy4", 32'(busy), 32'd0);
    check("gl_rise",  32'(rise), 32'd0);
    check("gl_level", 32'(level), 32'd0);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    check("gl_gcnt", 32'(gcnt), 32'd1);
`endif

    // Clean rise: accepted on the 4th sampling edge
    sig = 1'b1;
    tick(); tick(); tick();
    check("r_level3", 32'(level), 32'd0);
    check("r_rise3",  32'(rise),  32'd0);
    tick();
    check("r_level4", 32'(level), 32'd1);
    check("r_rise4",  32'(rise),  32'd1);
    check("r_busy4",  32'(busy),  32'd0);
    check("r_ecnt4",  32'(ecnt),  32'd1);
    tick();
    check("r_rise5",  32'(rise),  32'd0);
    check("r_level5", 32'(level), 32'd1);

    // Clean fall
    sig = 1'b0;
    tick(); tick(); tick();
    check("f_busy3",  32'(busy),  32'd1);
    check("f_fall3",  32'(fall),  32'd0);
    tick();
    check("f_fall4",  32'(fall),  32'd1);
    check("f_rise4",  32'(rise),  32'd0);
    check("f_level4", 32'(level), 32'd0);
    tick();
    check("f_fall5",  32'(fall),  32'd0);
    check("f_ecnt",   32'(ecnt),  32'd1);

    // Clear, then five clean pulses
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_ecnt", 32'(ecnt), 32'd0);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    check("clr_gcnt", 32'(gcnt), 32'd0);
`endif
    for (int p = 0; p < 5; p++) begin
      sig = 1'b1; repeat (6) tick();
      sig = 1'b0; repeat (6) tick();
    end
    check("p5_ecnt", 32'(ecnt), 32'd5);

    // Clear coincident with the 6th rise wins
    sig = 1'b1;
    tick(); tick(); tick();
    clr = 1'b1;
    tick();
    check("p6_rise", 32'(rise), 32'd1);
    check("p6_ecnt", 32'(ecnt), 32'd0);
    clr = 1'b0;
    tick();
    check("p6_ecnt_hold", 32'(ecnt), 32'd0);
    sig = 1'b0; repeat (6) tick();
    check("p6_level", 32'(level), 32'd0);

    // Toggling every cycle never qualifies
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sig = (i % 2 == 0);
      tick();
      seen = seen | rise | fall;
    end
    sig = 1'b0;
    tick_watch(4);
    check("tog_strb",  32'(seen),  32'd0);
    check("tog_level", 32'(level), 32'd0);

    // 4-bit counter saturates at 15
    for (int p = 0; p < 17; p++) begin
      sig2 = 1'b1; repeat (4) tick();
      sig2 = 1'b0; repeat (4) tick();
      if (p == 13) check("sat_14", 32'(ecnt2), 32'd14);
      if (p == 14) check("sat_15", 32'(ecnt2), 32'd15);
    end
    check("sat_17", 32'(ecnt2), 32'd15);
    check("sat_lvl", 32'(level2), 32'd0);

    // Async reset during QUAL_HI with qcnt=2
    sig = 1'b1;
    tick(); tick();
    check("mq_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mq_busy_rst",  32'(busy),  32'd0);
    check("mq_level_rst", 32'(level), 32'd0);
    check("mq_ecnt2_rst", 32'(ecnt2), 32'd0);
    sig = 1'b0;
    tick();
    rst = 1'b0;
    seen = 1'b0;
    tick_watch(6);
    check("mq_strb",  32'(seen),  32'd0);
    check("mq_level", 32'(level), 32'd0);
    check("mq_busy2", 32'(busy),  32'd0);

    // Async reset from accepted high returns level to INIT_LEVEL at once
    sig = 1'b1;
    repeat (4) tick();
    check("hr_level", 32'(level), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("hr_level_rst", 32'(level), 32'd0);
    check("hr_ecnt_rst",  32'(ecnt),  32'd0);
    sig = 1'b0;
    tick();
    rst = 1'b0;
    seen = 1'b0;
    tick_watch(5);
    check("hr_strb", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
